// File: rtl/wb_sram_bank_bridge.sv
// -----------------------------------------------------------------------------
// wb_sram_bank_bridge
//
// Wishbone classic slave mapping a contiguous, size-aligned address window onto
// NUM_SRAMS single-port OpenRAM macros through their RW port 0. Only the
// addressed macro is chip-selected, for one cycle; read data is registered
// before it is returned on the bus.
//
// Address layout (byte address):
//   [ADDR_WIDTH+1:2]                         word index inside a macro
//   [ADDR_WIDTH+1+BANK_BITS:ADDR_WIDTH+2]    bank (macro number)
//   [31:ADDR_WIDTH+2+BANK_BITS]              must equal BASE_ADDR to hit
// Bank NUM_SRAMS is the statistics register slot; banks above it read as 0
// and swallow writes.
//
// Build option:
//   BRIDGE_STATS_EN  when defined, bank NUM_SRAMS word 0 reads
//                    {rd_count[15:0], wr_count[15:0]} (saturating counts of
//                    acked macro reads/writes); any write to it clears both.
//                    When undefined, that bank behaves as unpopulated.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock (macros share it), sync active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone classic controls
//   wbs_sel_i, wbs_adr_i        byte selects, byte address
//   wbs_dat_i / wbs_dat_o       write data / read data (0 except during ack)
//   wbs_ack_o                   single-cycle acknowledge
//   sram_csb0                   per-macro chip select, active-low
//   sram_web0, sram_wmask0      shared write enable (active-low), byte mask
//   sram_addr0, sram_din0       shared word address and write data
//   sram_dout0                  concatenated macro read data, macro k at [32k+:32]
// -----------------------------------------------------------------------------
module wb_sram_bank_bridge #(
  parameter int          NUM_SRAMS  = 4,
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          READ_LAT   = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_SRAMS-1:0]    sram_csb0,
  output logic                    sram_web0,
  output logic [3:0]              sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [31:0]             sram_din0,
  input  logic [NUM_SRAMS*32-1:0] sram_dout0
);

  localparam int BANK_BITS = $clog2(NUM_SRAMS + 1);
  localparam int HIT_LSB   = ADDR_WIDTH + 2 + BANK_BITS;
  localparam int LAT_W     = $clog2(READ_LAT + 1);

  localparam logic [BANK_BITS-1:0] STATS_BANK = BANK_BITS'(NUM_SRAMS);
  localparam logic [LAT_W-1:0]     LAT_LAST   = LAT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_ACK
  } stateT;

  stateT stateQ, stateNext;

  logic [LAT_W-1:0]      latCntQ, latCntNext;
  logic                  weQ, weNext;
  logic [BANK_BITS-1:0]  bankQ, bankNext;
  logic                  macroQ, macroNext;
  logic [NUM_SRAMS-1:0]  csbQ, csbNext;
  logic                  webQ, webNext;
  logic [3:0]            wmaskQ, wmaskNext;
  logic [ADDR_WIDTH-1:0] addrQ, addrNext;
  logic [31:0]           dinQ, dinNext;
  logic [31:0]           datQ, datNext;

  // Address decode of the live request.
  logic [ADDR_WIDTH-1:0] wordIdx;
  logic [BANK_BITS-1:0]  bankIdx;
  logic                  hit, request, populated, needMacro;
  logic [31:0]           statsRdata;
  logic [31:0]           rdSlice;

  assign wordIdx   = wbs_adr_i[ADDR_WIDTH+1:2];
  assign bankIdx   = wbs_adr_i[HIT_LSB-1:ADDR_WIDTH+2];
  assign hit       = (wbs_adr_i[31:HIT_LSB] == BASE_ADDR[31:HIT_LSB]);
  assign request   = wbs_cyc_i && wbs_stb_i && hit;
  assign populated = (bankIdx < STATS_BANK);
  // A write with no byte selected changes nothing, so it skips the macro.
  assign needMacro = populated && !(wbs_we_i && (wbs_sel_i == 4'h0));

  // Byte-address bits below the word and the access-class flag in the default
  // build are intentionally not consumed.
  logic unusedBits;
  assign unusedBits = ^{wbs_adr_i[1:0], macroQ};

  // Select the dout slice of the latched bank with constant indices only.
  always_comb begin
    rdSlice = '0;
    for (int k = 0; k < NUM_SRAMS; k++) begin
      if (bankQ == BANK_BITS'(k)) rdSlice = sram_dout0[k*32 +: 32];
    end
  end

`ifdef BRIDGE_STATS_EN
  logic [15:0] rdCntQ, wrCntQ;
  logic        statsWord0, statsClear;

  assign statsWord0 = (bankIdx == STATS_BANK) && (wordIdx == '0);
  assign statsRdata = statsWord0 ? {rdCntQ, wrCntQ} : 32'h0;
  assign statsClear = (stateQ == ST_IDLE) && request && wbs_we_i && statsWord0;

  // Counts are taken in the ACK cycle so aborted accesses are never counted.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rdCntQ <= 16'h0;
      wrCntQ <= 16'h0;
    end else if (statsClear) begin
      rdCntQ <= 16'h0;
      wrCntQ <= 16'h0;
    end else if ((stateQ == ST_ACK) && macroQ) begin
      if (weQ) begin
        if (wrCntQ != 16'hFFFF) wrCntQ <= wrCntQ + 16'd1;
      end else begin
        if (rdCntQ != 16'hFFFF) rdCntQ <= rdCntQ + 16'd1;
      end
    end
  end
`else
  assign statsRdata = 32'h0;
`endif

  // Next-state and next-output logic. Every macro-facing output is registered,
  // so the chip select asserted on acceptance is seen only in the ACCESS cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    stateNext  = stateQ;
    latCntNext = latCntQ;
    weNext     = weQ;
    bankNext   = bankQ;
    macroNext  = macroQ;
    csbNext    = '1;
    webNext    = webQ;
    wmaskNext  = wmaskQ;
    addrNext   = addrQ;
    dinNext    = dinQ;
    datNext    = datQ;

    case (stateQ)
      ST_IDLE: begin
        if (request) begin
          weNext    = wbs_we_i;
          bankNext  = bankIdx;
          macroNext = needMacro;
          if (needMacro) begin
            for (int k = 0; k < NUM_SRAMS; k++) begin
              if (bankIdx == BANK_BITS'(k)) csbNext[k] = 1'b0;
            end
            webNext    = ~wbs_we_i;
            wmaskNext  = wbs_we_i ? wbs_sel_i : 4'h0;
            addrNext   = wordIdx;
            dinNext    = wbs_dat_i;
            latCntNext = '0;
            stateNext  = ST_ACCESS;
          end else begin
            datNext   = wbs_we_i ? 32'h0 : statsRdata;
            stateNext = ST_ACK;
          end
        end
      end

      // The macro samples at the end of this cycle whether or not the master
      // is still there; a dropped cycle only suppresses the acknowledge.
      ST_ACCESS: begin
        if (!wbs_cyc_i)  stateNext = ST_IDLE;
        else if (weQ)    stateNext = ST_ACK;
        else             stateNext = ST_WAIT;
      end

      ST_WAIT: begin
        if (!wbs_cyc_i) begin
          stateNext = ST_IDLE;
        end else if (latCntQ == LAT_LAST) begin
          datNext   = rdSlice;
          stateNext = ST_ACK;
        end else begin
          latCntNext = latCntQ + 1'b1;
        end
      end

      ST_ACK: begin
        datNext   = 32'h0;
        stateNext = ST_IDLE;
      end

      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (wb_rst_i) begin
      stateQ  <= ST_IDLE;
      latCntQ <= '0;
      weQ     <= 1'b0;
      bankQ   <= '0;
      macroQ  <= 1'b0;
      csbQ    <= '1;
      webQ    <= 1'b1;
      wmaskQ  <= 4'h0;
      addrQ   <= '0;
      dinQ    <= 32'h0;
      datQ    <= 32'h0;
    end else begin
      stateQ  <= stateNext;
      latCntQ <= latCntNext;
      weQ     <= weNext;
      bankQ   <= bankNext;
      macroQ  <= macroNext;
      csbQ    <= csbNext;
      webQ    <= webNext;
      wmaskQ  <= wmaskNext;
      addrQ   <= addrNext;
      dinQ    <= dinNext;
      datQ    <= datNext;
    end
  end

  assign wbs_ack_o   = (stateQ == ST_ACK);
  assign wbs_dat_o   = datQ;
  assign sram_csb0   = csbQ;
  assign sram_web0   = webQ;
  assign sram_wmask0 = wmaskQ;
  assign sram_addr0  = addrQ;
  assign sram_din0   = dinQ;

endmodule

// File: tb/tb_wb_sram_bank_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_sram_bank_bridge
//
// Self-checking bench for wb_sram_bank_bridge at default parameters. A
// behavioural model of four OpenRAM macros sits on the SRAM side. A table of
// directed transactions is applied and compared, followed by hand-written
// abort and reset sequences. Monitors watch chip-select and acknowledge shape
// throughout. Expected stats values follow BRIDGE_STATS_EN.
// -----------------------------------------------------------------------------
module tb_wb_sram_bank_bridge;

  localparam int NS = 4;
  localparam int AW = 9;

  logic           wb_clk_i = 1'b0;
  logic           wb_rst_i;
  logic           wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]     wbs_sel_i;
  logic [31:0]    wbs_adr_i, wbs_dat_i;
  logic           wbs_ack_o;
  logic [31:0]    wbs_dat_o;
  logic [NS-1:0]  sram_csb0;
  logic           sram_web0;
  logic [3:0]     sram_wmask0;
  logic [AW-1:0]  sram_addr0;
  logic [31:0]    sram_din0;
  logic [NS*32-1:0] sram_dout0;

  wb_sram_bank_bridge dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Macro model: samples at the clock edge when selected, dout updates after it.
  logic [31:0] mem [NS][512];

  initial begin
    for (int k = 0; k < NS; k++)
      for (int w = 0; w < 512; w++) mem[k][w] = 32'h0;
    sram_dout0 = '0;
  end

  always @(posedge wb_clk_i) begin
    for (int k = 0; k < NS; k++) begin
      if (!sram_csb0[k]) begin
        if (!sram_web0) begin
          for (int b = 0; b < 4; b++)
            if (sram_wmask0[b]) mem[k][sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
        end else begin
          sram_dout0[32*k +: 32] <= mem[k][sram_addr0];
        end
      end
    end
  end

  // Shape monitors: at most one csb low, never two cycles running, ack one cycle.
  int  ackCount = 0;
  int  csbViol  = 0;
  int  ackViol  = 0;
  logic prevLow = 1'b0;
  logic prevAck = 1'b0;

  always @(negedge wb_clk_i) begin
    if ($countones(~sram_csb0) > 1) csbViol <= csbViol + 1;
    if (prevLow && (sram_csb0 != 4'hF)) csbViol <= csbViol + 1;
    if (prevAck && wbs_ack_o) ackViol <= ackViol + 1;
    if (wbs_ack_o) ackCount <= ackCount + 1;
    prevLow <= (sram_csb0 != 4'hF);
    prevAck <= wbs_ack_o;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One Wishbone transaction, started #1 after a rising edge (cycle 0).
  task automatic runTxn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat, output int ackCyc,
                        output logic [3:0] csb1, output logic web1,
                        output logic [3:0] wm1, output logic [8:0] ad1,
                        output logic [31:0] din1, output logic [31:0] rdata,
                        output logic [31:0] after, output logic lowSeen);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
    ackCyc = -1; rdata = 32'h0; lowSeen = 1'b0;
    csb1 = 4'hF; web1 = 1'b1; wm1 = 4'h0; ad1 = 9'h0; din1 = 32'h0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge wb_clk_i); #1;
      if (c == 1) begin
        csb1 = sram_csb0; web1 = sram_web0; wm1 = sram_wmask0;
        ad1 = sram_addr0; din1 = sram_din0;
      end
      if (sram_csb0 != 4'hF) lowSeen = 1'b1;
      if (wbs_ack_o) begin
        ackCyc = c;
        rdata  = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    @(posedge wb_clk_i); #1;
    after = wbs_dat_o;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    bit          macro;
    logic [3:0]  csb;
    logic        web;
    logic [3:0]  wmask;
    logic [8:0]  addr;
    int          ack;
    logic [31:0] rdata;
  } vecT;

  vecT vecs[$];

  task automatic addVec(input string name, input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat, input bit macro,
                        input logic [3:0] csb, input logic [3:0] wmask,
                        input logic [8:0] addr, input int ack, input logic [31:0] rdata);
    vecT v;
    v.name = name; v.we = we; v.sel = sel; v.adr = adr; v.dat = dat;
    v.macro = macro; v.csb = csb; v.web = ~we; v.wmask = wmask;
    v.addr = addr; v.ack = ack; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  int          ackCyc, base;
  logic [3:0]  csb1, wm1;
  logic        web1, lowSeen;
  logic [8:0]  ad1;
  logic [31:0] din1, rdata, after;
  logic [31:0] statsFirst, statsLast;

  initial begin
`ifdef BRIDGE_STATS_EN
    statsFirst = 32'h0001_0002;
    statsLast  = 32'h0002_0002;
`else
    statsFirst = 32'h0;
    statsLast  = 32'h0;
`endif
    //      name          we    sel    adr            dat           mac  csb      wmask   addr    ack rdata
    addVec("wr bank1",    1'b1, 4'hF, 32'h3000_0804, 32'hDEADBEEF, 1, 4'b1101, 4'hF,    9'd1,   2, 32'h0);
    addVec("rd bank1",    1'b0, 4'hF, 32'h3000_0804, 32'h0,        1, 4'b1101, 4'h0,    9'd1,   3, 32'hDEADBEEF);
    addVec("wr bank3",    1'b1, 4'hF, 32'h3000_1FFC, 32'h11223344, 1, 4'b0111, 4'hF,    9'h1FF, 2, 32'h0);
    addVec("rd stats",    1'b0, 4'hF, 32'h3000_2000, 32'h0,        0, 4'hF,    4'h0,    9'h0,   1, statsFirst);
    addVec("wr stats",    1'b1, 4'hF, 32'h3000_2000, 32'h0,        0, 4'hF,    4'h0,    9'h0,   1, 32'h0);
    addVec("rd stats clr",1'b0, 4'hF, 32'h3000_2000, 32'h0,        0, 4'hF,    4'h0,    9'h0,   1, 32'h0);
    addVec("wr byte1",    1'b1, 4'b0010, 32'h3000_1FFC, 32'h0000_00AA, 1, 4'b0111, 4'b0010, 9'h1FF, 2, 32'h0);
    addVec("wr sel0",     1'b1, 4'h0, 32'h3000_1FFC, 32'h12345678, 0, 4'hF,    4'h0,    9'h0,   1, 32'h0);
    addVec("rd bank3",    1'b0, 4'hF, 32'h3000_1FFC, 32'h0,        1, 4'b0111, 4'h0,    9'h1FF, 3, 32'h1122_0044);
    addVec("rd bank5",    1'b0, 4'hF, 32'h3000_2800, 32'h0,        0, 4'hF,    4'h0,    9'h0,   1, 32'h0);
    addVec("wr bank5",    1'b1, 4'hF, 32'h3000_2800, 32'hFFFFFFFF, 0, 4'hF,    4'h0,    9'h0,   1, 32'h0);
    addVec("wr bank0",    1'b1, 4'hF, 32'h3000_0014, 32'hCAFEF00D, 1, 4'b1110, 4'hF,    9'd5,   2, 32'h0);
    addVec("rd bank0",    1'b0, 4'hF, 32'h3000_0014, 32'h0,        1, 4'b1110, 4'h0,    9'd5,   3, 32'hCAFEF00D);
    addVec("miss above",  1'b0, 4'hF, 32'h3000_4000, 32'h0,        0, 4'hF,    4'h0,    9'h0,  -1, 32'h0);
    addVec("miss below",  1'b1, 4'hF, 32'h2FFF_FFFC, 32'h0,        0, 4'hF,    4'h0,    9'h0,  -1, 32'h0);
    addVec("rd bank7",    1'b0, 4'hF, 32'h3000_3FFC, 32'h0,        0, 4'hF,    4'h0,    9'h0,   1, 32'h0);
    addVec("rd stats w1", 1'b0, 4'hF, 32'h3000_2004, 32'h0,        0, 4'hF,    4'h0,    9'h0,   1, 32'h0);
    addVec("rd stats end",1'b0, 4'hF, 32'h3000_2000, 32'h0,        0, 4'hF,    4'h0,    9'h0,   1, statsLast);

    // Reset state.
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset csb",   32'(sram_csb0),   32'hF);
    check("reset web",   32'(sram_web0),   32'h1);
    check("reset wmask", 32'(sram_wmask0), 32'h0);
    check("reset addr",  32'(sram_addr0),  32'h0);
    check("reset din",   sram_din0,        32'h0);
    check("reset ack",   32'(wbs_ack_o),   32'h0);
    check("reset dat",   wbs_dat_o,        32'h0);
    wb_rst_i = 1'b0;

    foreach (vecs[i]) begin
      runTxn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, ackCyc,
             csb1, web1, wm1, ad1, din1, rdata, after, lowSeen);
      check({vecs[i].name, " ack cycle"}, 32'(ackCyc), 32'(vecs[i].ack));
      if (vecs[i].macro) begin
        check({vecs[i].name, " csb"},   32'(csb1), 32'(vecs[i].csb));
        check({vecs[i].name, " web"},   32'(web1), 32'(vecs[i].web));
        check({vecs[i].name, " wmask"}, 32'(wm1),  32'(vecs[i].wmask));
        check({vecs[i].name, " addr"},  32'(ad1),  32'(vecs[i].addr));
        if (vecs[i].we) check({vecs[i].name, " din"}, din1, vecs[i].dat);
      end else begin
        check({vecs[i].name, " no csb"}, 32'(lowSeen), 32'h0);
      end
      if (!vecs[i].we && vecs[i].ack > 0) check({vecs[i].name, " rdata"}, rdata, vecs[i].rdata);
      if (vecs[i].ack > 0) check({vecs[i].name, " dat after ack"}, after, 32'h0);
    end

    // Drop cyc during WAIT: the read completes at the macro, no ack follows.
    base = ackCount;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0804;
    @(posedge wb_clk_i); #1;
    check("abort wait csb", 32'(sram_csb0), 32'b1101);
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (6) @(posedge wb_clk_i);
    #1;
    check("abort wait no ack", 32'(ackCount - base), 32'h0);
    check("abort wait dat", wbs_dat_o, 32'h0);
    runTxn(1'b0, 4'hF, 32'h3000_0804, 32'h0, ackCyc, csb1, web1, wm1, ad1, din1, rdata, after, lowSeen);
    check("after abort ack cycle", 32'(ackCyc), 32'd3);
    check("after abort rdata", rdata, 32'hDEADBEEF);

    // Drop cyc during ACCESS.
    base = ackCount;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0014;
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (6) @(posedge wb_clk_i);
    #1;
    check("abort access no ack", 32'(ackCount - base), 32'h0);

    // Reset during ACCESS: outputs back to idle next cycle, no ack ever.
    base = ackCount;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_adr_i = 32'h3000_0014; wbs_dat_i = 32'h5555_5555;
    @(posedge wb_clk_i); #1;
    check("rst access csb", 32'(sram_csb0), 32'b1110);
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst next csb", 32'(sram_csb0), 32'hF);
    check("rst next ack", 32'(wbs_ack_o), 32'h0);
    wb_rst_i = 1'b0;
    repeat (8) @(posedge wb_clk_i);
    #1;
    check("rst no ack", 32'(ackCount - base), 32'h0);
    // The macro itself sampled the write in the ACCESS cycle.
    runTxn(1'b0, 4'hF, 32'h3000_0014, 32'h0, ackCyc, csb1, web1, wm1, ad1, din1, rdata, after, lowSeen);
    check("after rst ack cycle", 32'(ackCyc), 32'd3);
    check("after rst rdata", rdata, 32'h5555_5555);

    @(negedge wb_clk_i);
    check("csb shape", 32'(csbViol), 32'h0);
    check("ack width", 32'(ackViol), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
